// File: rtl/alu_mul_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_sequencer_pkg
// Description : Shared constants for the EX-stage multiply sequencer:
//               sequencer state encodings, RV32M MUL decode fields and the
//               ALU control codes the sequencer drives onto the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_mul_sequencer_pkg;

    // Sequencer state encodings
    localparam logic [1:0] MULSEQ_IDLE  = 2'd0;
    localparam logic [1:0] MULSEQ_ACC   = 2'd1;
    localparam logic [1:0] MULSEQ_SHIFT = 2'd2;
    localparam logic [1:0] MULSEQ_DONE  = 2'd3;

    // RV32M MUL decode fields (used by the decoder to raise start)
    localparam logic [6:0] RV32_FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] RV32_FUNCT3_MUL    = 3'b000;

    // EX-stage ALU control codes
    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_LSHIFT = 5'b00010;
    localparam logic [4:0] ALU_NOP    = 5'b11111;

endpackage : alu_mul_sequencer_pkg
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_sequencer
// Description : Multi-cycle RV32M MUL (low XLEN bits) on the shared EX ALU
//               by iterative shift-add. Idle: ALU operands/control pass
//               straight through. Busy: the sequencer owns the ALU and
//               stalls the pipeline until the product is ready.
// Ports       : clk, reset (async, active-high)
//               start, flush         - MUL request / pipeline flush
//               op_a, op_b           - multiplicand / multiplier
//               ex_alu_ctrl/ex_a/ex_b- normal EX ALU control and operands
//               alu_result           - ALU output
//               alu_ctrl/alu_a/alu_b - control and operands driven to ALU
//               stall, done, product - pipeline stall, result pulse, result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int EARLY_EXIT = 0,
    parameter int CNT_W      = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      ex_alu_ctrl,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [XLEN-1:0] alu_result,
    output logic [4:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] product
);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_product;

    logic            w_accept;
    logic            w_last;
    logic [XLEN-1:0] w_mplier_shr;

    assign w_accept     = start & ~flush;
    assign w_mplier_shr = r_mplier >> 1;
    // Final iteration: all XLEN bits consumed, or (early exit) nothing left
    // in the multiplier that could still add to the accumulator.
    assign w_last = (r_cnt == CNT_W'(XLEN - 1)) ||
                    ((EARLY_EXIT != 0) && (w_mplier_shr == '0));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MULSEQ_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and ALU mux / handshake outputs
    always_comb begin
        w_next_state = r_state;
        alu_ctrl     = ex_alu_ctrl;
        alu_a        = ex_a;
        alu_b        = ex_b;
        stall        = 1'b0;
        done         = 1'b0;
        case (r_state)
            MULSEQ_IDLE: begin
                stall = w_accept;
                if (w_accept) begin
                    w_next_state = MULSEQ_ACC;
                end
            end
            MULSEQ_ACC: begin
                stall = 1'b1;
                alu_a = r_acc;
                alu_b = r_mcand;
                alu_ctrl = r_mplier[0] ? ALU_ADD : ALU_NOP;
                w_next_state = flush ? MULSEQ_IDLE : MULSEQ_SHIFT;
            end
            MULSEQ_SHIFT: begin
                stall    = 1'b1;
                alu_ctrl = ALU_LSHIFT;
                alu_a    = r_mcand;
                alu_b    = XLEN'(1);
                if (flush) begin
                    w_next_state = MULSEQ_IDLE;
                end else if (w_last) begin
                    w_next_state = MULSEQ_DONE;
                end else begin
                    w_next_state = MULSEQ_ACC;
                end
            end
            MULSEQ_DONE: begin
                // ALU is handed back to the pipeline for this cycle.
                done         = 1'b1;
                w_next_state = MULSEQ_IDLE;
            end
            default: begin
                w_next_state = MULSEQ_IDLE;
            end
        endcase
        // Stall must not leak out combinationally from start during reset.
        if (reset) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                MULSEQ_IDLE: begin
                    if (w_accept) begin
                        r_acc    <= '0;
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_cnt    <= '0;
                    end
                end
                MULSEQ_ACC: begin
                    if (r_mplier[0]) begin
                        r_acc <= alu_result;
                    end
                end
                MULSEQ_SHIFT: begin
                    r_mcand  <= alu_result;
                    r_mplier <= w_mplier_shr;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Capture on the transition into DONE so product is
                    // already valid during the done pulse.
                    if (w_next_state == MULSEQ_DONE) begin
                        r_product <= r_acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule : alu_mul_sequencer
`default_nettype wire
